alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge), reset_n input 1 (asynchronous, active-low).
REQ-002 Requester side inputs SHALL be:
  - start  in  1  request pulse
  - op  in  3  operation code
  - a  in  16  first operand
  - b  in  16  second operand
  - wide  in  1  16-bit request
  - cin_use  in  1  seed carry from flag
REQ-003 Requester side outputs SHALL be:
  - busy  out  1  operation in progress
  - done  out  1  one-cycle completion pulse
  - result  out  16  registered result
  - carry  out  1  carry/borrow flag register
REQ-004 ALU side outputs SHALL be:
  - alu_a1  out  8  operand byte
  - alu_a2  out  8  operand byte
  - alu_opFlag  out  8  one-hot operation select
  - alu_eFlag  out  1  evaluate enable
  - alu_cin  out  1  carry/borrow in
REQ-005 ALU side inputs SHALL be:
  - alu_out  in  8  combinational result byte
  - alu_cout  in  1  carry/borrow out

Function
REQ-006 op SHALL map to alu_opFlag as follows: 0 NOT=8'h01, 1 OR=8'h02, 2 AND=8'h04, 3 ADD=8'h08, 4 SUB=8'h10, 5 XOR=8'h20; op 6/7 SHALL drive 8'h00.
REQ-007 The FSM states SHALL be IDLE, LO, HI, DONE, with transitions:
  - IDLE->LO on start;
  - LO->HI if wide latched, else LO->DONE;
  - HI->DONE;
  - DONE->IDLE unconditionally.
REQ-008 In IDLE with start=1, op, a, b, wide and cin_use SHALL be latched; start SHALL be ignored in every other state.
REQ-009 busy SHALL be 1 in LO, HI and DONE, and 0 in IDLE.
REQ-010 LO SHALL drive alu_a1=a[7:0], alu_a2=b[7:0] and alu_eFlag=1; alu_cin SHALL be the carry register if cin_use was latched, else 0.
REQ-011 HI SHALL drive alu_a1=a[15:8], alu_a2=b[15:8] and alu_eFlag=1; alu_cin SHALL be the alu_cout captured at the end of LO.
REQ-012 In IDLE and DONE, alu_eFlag, alu_opFlag, alu_a1, alu_a2 and alu_cin SHALL all be 0.
REQ-013 alu_out SHALL be captured at the end of LO into result[7:0] and at the end of HI into result[15:8].
REQ-014 For a narrow operation, result[15:8] SHALL be written 8'h00.
REQ-015 carry SHALL update only for ADD/SUB: from the LO alu_cout for narrow operations, from the HI alu_cout for wide ones; for every other op, carry SHALL hold.
REQ-016 SUB carry SHALL mean borrow, i.e. a1 < a2 + cin.
REQ-017 done SHALL be 1 exactly in DONE; latency from the start edge to done SHALL be 2 cycles narrow and 3 cycles wide.
REQ-018 result SHALL hold its value until the next operation's LO capture.
REQ-019 For op 6/7, the full sequence SHALL still run: result=0, carry held, done pulses.
REQ-020 A start in the DONE cycle SHALL be ignored; a new start SHALL be accepted in IDLE at the earliest.

Reset
REQ-021 Asserting reset_n low SHALL asynchronously force: state IDLE, busy=0, done=0, result=16'h0000, carry=0, and all alu_* outputs 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no done pulse and no update of carry.

Configuration
REQ-023 With ALU_SEQ_WIDE_EN defined, 16-bit two-pass operation SHALL be available as specified above.
REQ-024 Without ALU_SEQ_WIDE_EN:
  - wide SHALL be ignored (treated as 0);
  - state HI SHALL be absent;
  - a[15:8] and b[15:8] SHALL be unused;
  - result[15:8] SHALL be tied to 0.

Structure
REQ-025 A shared package alu_pkg SHALL hold the op code constants, the one-hot opFlag constants and the FSM state enum.
REQ-026 A sub-module alu_seq_opdec SHALL implement the combinational op to opFlag decode.
REQ-027 The ALU itself SHALL be instantiated outside this block.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
  - Narrow ADD: a=0x00F0, b=0x0020, cin_use=0 -> result=0x0010, carry=1, done 2 cycles after start.
  - Wide ADD: a=0x00FF, b=0x0001 -> LO alu_cout=1 feeds HI alu_cin -> result=0x0100, carry=0, done at cycle 3.
  - Narrow SUB: a=0x05, b=0x07 -> result=0x00FE, carry=1; then ADD 0x01+0x01 with cin_use=1 -> alu_cin=1 in LO, result=0x0003.
  - XOR: 0xAA^0x0F -> result=0x00A5, carry unchanged; a start pulse during LO -> ignored, exactly one done.
  - Reset asserted in HI -> busy=0, result=0, carry=0 immediately, with no done pulse.
  - op=7 -> alu_opFlag=0x00, result=0x0000, done pulses; without ALU_SEQ_WIDE_EN, wide=1 runs 2-cycle narrow.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the alu_seq byte-serial ALU sequencer.
//
// Contents:
//   OP_*        3-bit operation codes presented on alu_seq.op
//   OPF_*       one-hot operation selects driven on alu_seq.alu_opFlag
//   alu_state_e sequencer FSM state encoding
//   is_arith()  true for the ops that update the carry/borrow flag
//
// Configuration macro: ALU_SEQ_WIDE_EN
//   When defined, the FSM includes the ST_HI state used by 16-bit two-pass
//   operations. When undefined, ST_HI does not exist.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] OP_NOT = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [7:0] OPF_NONE = 8'h00;
  localparam logic [7:0] OPF_NOT  = 8'h01;
  localparam logic [7:0] OPF_OR   = 8'h02;
  localparam logic [7:0] OPF_AND  = 8'h04;
  localparam logic [7:0] OPF_ADD  = 8'h08;
  localparam logic [7:0] OPF_SUB  = 8'h10;
  localparam logic [7:0] OPF_XOR  = 8'h20;

  // Encodings are fixed so the debug state value means the same thing in
  // both builds; 2'd2 is simply unused when the wide pass is compiled out.
`ifdef ALU_SEQ_WIDE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_DONE = 2'd3
  } alu_state_e;
`endif

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_opdec.sv
// ---------------------------------------------------------------------------
// alu_seq_opdec -- combinational decode of the 3-bit op code into the
// one-hot ALU operation select.
//
// Ports:
//   op_i        in  3  operation code
//   op_flag_o   out 8  one-hot select (8'h00 for op 6/7)
//   op_valid_o  out 1  1 when op maps to a real ALU operation
// ---------------------------------------------------------------------------
module alu_seq_opdec
  import alu_pkg::*;
(
  input  logic [2:0] op_i,
  output logic [7:0] op_flag_o,
  output logic       op_valid_o
);

  always_comb begin
    op_flag_o = OPF_NONE;
    case (op_i)
      OP_NOT:  op_flag_o = OPF_NOT;
      OP_OR:   op_flag_o = OPF_OR;
      OP_AND:  op_flag_o = OPF_AND;
      OP_ADD:  op_flag_o = OPF_ADD;
      OP_SUB:  op_flag_o = OPF_SUB;
      OP_XOR:  op_flag_o = OPF_XOR;
      default: op_flag_o = OPF_NONE;
    endcase
  end

  assign op_valid_o = (op_flag_o != OPF_NONE);

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequences 8-bit or 16-bit operations through an external
// byte-wide combinational ALU, one byte per cycle (low byte first).
//
// Configuration macro: ALU_SEQ_WIDE_EN
//   Defined   : wide=1 runs a second (high-byte) pass in ST_HI.
//   Undefined : wide is ignored, ST_HI is absent, a/b[15:8] are unused and
//               result[15:8] is tied to zero.
//
// Ports:
//   clk, reset_n           clock (rising edge), async active-low reset
//   start                  request pulse, accepted only in IDLE
//   op, a, b, wide, cin_use request fields, latched on accepted start
//   busy, done             in-progress flag, one-cycle completion pulse
//   result, carry          registered result and carry/borrow flag
//   alu_a1, alu_a2         operand bytes to the ALU
//   alu_opFlag, alu_eFlag  one-hot op select and evaluate enable
//   alu_cin                carry/borrow into the ALU
//   alu_out, alu_cout      combinational ALU result byte and carry out
//   dbg_state              current FSM state (alu_state_e encoding)
//
// Handshake: a request is taken on a rising edge where start=1 and the
// block is in IDLE (busy=0); start is ignored at any other time. done is
// high for exactly the one cycle the FSM spends in DONE, at which point
// result/carry already hold the final values.
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        wide,
  input  logic        cin_use,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic [7:0]  alu_a1,
  output logic [7:0]  alu_a2,
  output logic [7:0]  alu_opFlag,
  output logic        alu_eFlag,
  output logic        alu_cin,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic [1:0]  dbg_state
);

  alu_state_e state_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] result_lo_q;
  logic       carry_q;
  logic [7:0] a1_q;
  logic [7:0] a2_q;
  logic [7:0] op_flag_q;
  logic       e_flag_q;
  logic       cin_q;
  logic       arith_q;
  logic       valid_q;

  logic [7:0] dec_flag;
  logic       dec_valid;

  alu_seq_opdec u_opdec (
    .op_i       (op),
    .op_flag_o  (dec_flag),
    .op_valid_o (dec_valid)
  );

  // Undefined op codes select no ALU function, so their result bytes are
  // forced to zero instead of trusting whatever the ALU drives.
  logic [7:0] cap_byte;
  assign cap_byte = valid_q ? alu_out : 8'h00;

`ifdef ALU_SEQ_WIDE_EN
  logic       wide_q;
  logic [7:0] a_hi_q;
  logic [7:0] b_hi_q;
  logic [7:0] result_hi_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_lo_q <= 8'h00;
      carry_q     <= 1'b0;
      a1_q        <= 8'h00;
      a2_q        <= 8'h00;
      op_flag_q   <= 8'h00;
      e_flag_q    <= 1'b0;
      cin_q       <= 1'b0;
      arith_q     <= 1'b0;
      valid_q     <= 1'b0;
`ifdef ALU_SEQ_WIDE_EN
      wide_q      <= 1'b0;
      a_hi_q      <= 8'h00;
      b_hi_q      <= 8'h00;
      result_hi_q <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_LO;
            busy_q    <= 1'b1;
            arith_q   <= is_arith(op);
            valid_q   <= dec_valid;
            // ALU drive is registered, so the low-byte operands are loaded
            // here and are stable for the whole LO cycle.
            op_flag_q <= dec_flag;
            a1_q      <= a[7:0];
            a2_q      <= b[7:0];
            e_flag_q  <= 1'b1;
            cin_q     <= cin_use ? carry_q : 1'b0;
`ifdef ALU_SEQ_WIDE_EN
            wide_q    <= wide;
            a_hi_q    <= a[15:8];
            b_hi_q    <= b[15:8];
`endif
          end
        end

        ST_LO: begin
          result_lo_q <= cap_byte;
`ifdef ALU_SEQ_WIDE_EN
          if (wide_q) begin
            state_q <= ST_HI;
            a1_q    <= a_hi_q;
            a2_q    <= b_hi_q;
            // Low-byte carry chains into the high-byte pass.
            cin_q   <= alu_cout;
          end else begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            result_hi_q <= 8'h00;
            if (arith_q) carry_q <= alu_cout;
            a1_q      <= 8'h00;
            a2_q      <= 8'h00;
            op_flag_q <= 8'h00;
            e_flag_q  <= 1'b0;
            cin_q     <= 1'b0;
          end
`else
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          if (arith_q) carry_q <= alu_cout;
          a1_q      <= 8'h00;
          a2_q      <= 8'h00;
          op_flag_q <= 8'h00;
          e_flag_q  <= 1'b0;
          cin_q     <= 1'b0;
`endif
        end

`ifdef ALU_SEQ_WIDE_EN
        ST_HI: begin
          state_q     <= ST_DONE;
          done_q      <= 1'b1;
          result_hi_q <= cap_byte;
          if (arith_q) carry_q <= alu_cout;
          a1_q      <= 8'h00;
          a2_q      <= 8'h00;
          op_flag_q <= 8'h00;
          e_flag_q  <= 1'b0;
          cin_q     <= 1'b0;
        end
`endif

        ST_DONE: begin
          // start seen here is dropped; the next request is taken in IDLE.
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q   <= ST_IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          a1_q      <= 8'h00;
          a2_q      <= 8'h00;
          op_flag_q <= 8'h00;
          e_flag_q  <= 1'b0;
          cin_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_WIDE_EN
  assign result = {result_hi_q, result_lo_q};
`else
  assign result = {8'h00, result_lo_q};
  // High operand bytes and wide have no function in the narrow-only build.
  logic unused_hi;
  assign unused_hi = ^{a[15:8], b[15:8], wide};
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign carry      = carry_q;
  assign alu_a1     = a1_q;
  assign alu_a2     = a2_q;
  assign alu_opFlag = op_flag_q;
  assign alu_eFlag  = e_flag_q;
  assign alu_cin    = cin_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- directed testbench for alu_seq. Contains a behavioural model
// of the external byte ALU, and checks results against hand-computed values.
// Builds with or without ALU_SEQ_WIDE_EN; wide vectors choose the expected
// values for the build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_SEQ_WIDE_EN
  localparam bit WIDE_BUILD = 1'b1;
`else
  localparam bit WIDE_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        wide = 1'b0;
  logic        cin_use = 1'b0;
  logic        busy, done, carry;
  logic [15:0] result;
  logic [7:0]  alu_a1, alu_a2, alu_opFlag, alu_out;
  logic        alu_eFlag, alu_cin, alu_cout;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];

  alu_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .wide       (wide),
    .cin_use    (cin_use),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry      (carry),
    .alu_a1     (alu_a1),
    .alu_a2     (alu_a2),
    .alu_opFlag (alu_opFlag),
    .alu_eFlag  (alu_eFlag),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .dbg_state  (dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- external ALU model ----
  always_comb begin
    alu_out  = 8'h00;
    alu_cout = 1'b0;
    case (alu_opFlag)
      8'h01: alu_out = ~alu_a1;
      8'h02: alu_out = alu_a1 | alu_a2;
      8'h04: alu_out = alu_a1 & alu_a2;
      8'h08: {alu_cout, alu_out} = {1'b0, alu_a1} + {1'b0, alu_a2} + {8'h00, alu_cin};
      8'h10: begin
        alu_out  = alu_a1 - alu_a2 - {7'h00, alu_cin};
        alu_cout = ({1'b0, alu_a1} < ({1'b0, alu_a2} + {8'h00, alu_cin}));
      end
      8'h20: alu_out = alu_a1 ^ alu_a2;
      default: ;
    endcase
  end

  // ---- done pulse counter (counts cycles with done high) ----
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it to completion.
  task automatic run_op(input string tag, input logic [2:0] op_v,
                        input logic [15:0] a_v, input logic [15:0] b_v,
                        input logic wide_v, input logic cin_v, input logic hold_v,
                        input logic [7:0] exp_flag, input logic exp_cin,
                        input logic [15:0] exp_res, input logic exp_c,
                        input int exp_lat, input logic exp_hi_cin);
    int n;
    int d0;
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v; wide = wide_v; cin_use = cin_v;
    exp_q.push_back(exp_res);
    d0 = done_cnt;
    @(posedge clk); #1;
    if (!hold_v) start = 1'b0;
    chk({tag, ".lo_busy"}, busy, 1'b1);
    chk({tag, ".lo_eflag"}, alu_eFlag, 1'b1);
    chk({tag, ".lo_opflag"}, alu_opFlag, exp_flag);
    chk({tag, ".lo_a1"}, alu_a1, a_v[7:0]);
    chk({tag, ".lo_a2"}, alu_a2, b_v[7:0]);
    chk({tag, ".lo_cin"}, alu_cin, exp_cin);
    n = 1;
    if (exp_lat == 3) begin
      @(posedge clk); #1;
      n = 2;
      start = 1'b0;
      chk({tag, ".hi_a1"}, alu_a1, a_v[15:8]);
      chk({tag, ".hi_a2"}, alu_a2, b_v[15:8]);
      chk({tag, ".hi_cin"}, alu_cin, exp_hi_cin);
    end
    while (done !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
    end
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".result"}, result, exp_q.pop_front());
    chk({tag, ".carry"}, carry, exp_c);
    chk({tag, ".done_eflag"}, alu_eFlag, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    // ---- reset ----
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.result", result, 16'h0000);
    chk("rst.carry", carry, 1'b0);
    chk("rst.alu", {alu_a1, alu_a2, alu_opFlag, alu_eFlag, alu_cin}, 26'h0);
    @(negedge clk) reset_n = 1'b1;

    // ---- directed vectors ----
    run_op("add_nar", OP_ADD, 16'h00F0, 16'h0020, 1'b0, 1'b0, 1'b0,
           OPF_ADD, 1'b0, 16'h0010, 1'b1, 2, 1'b0);
    run_op("add_wide", OP_ADD, 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0,
           OPF_ADD, 1'b0, WIDE_BUILD ? 16'h0100 : 16'h0000,
           WIDE_BUILD ? 1'b0 : 1'b1, WIDE_BUILD ? 3 : 2, 1'b1);
    run_op("sub_nar", OP_SUB, 16'h0005, 16'h0007, 1'b0, 1'b0, 1'b0,
           OPF_SUB, 1'b0, 16'h00FE, 1'b1, 2, 1'b0);
    run_op("add_cin", OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0,
           OPF_ADD, 1'b1, 16'h0003, 1'b0, 2, 1'b0);
    run_op("sub_brw", OP_SUB, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0,
           OPF_SUB, 1'b0, 16'h00FF, 1'b1, 2, 1'b0);
    run_op("xor_hold", OP_XOR, 16'h00AA, 16'h000F, 1'b0, 1'b0, 1'b1,
           OPF_XOR, 1'b0, 16'h00A5, 1'b1, 2, 1'b0);
    run_op("op7", 3'd7, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0,
           OPF_NONE, 1'b0, 16'h0000, 1'b1, 2, 1'b0);
    run_op("not", OP_NOT, 16'h003C, 16'h0055, 1'b0, 1'b0, 1'b0,
           OPF_NOT, 1'b0, 16'h00C3, 1'b1, 2, 1'b0);
    run_op("or", OP_OR, 16'h000F, 16'h00F0, 1'b0, 1'b0, 1'b0,
           OPF_OR, 1'b0, 16'h00FF, 1'b1, 2, 1'b0);
    run_op("and_cin", OP_AND, 16'h00F3, 16'h003C, 1'b0, 1'b1, 1'b0,
           OPF_AND, 1'b1, 16'h0030, 1'b1, 2, 1'b0);
    run_op("op6", 3'd6, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0,
           OPF_NONE, 1'b0, 16'h0000, 1'b1, 2, 1'b0);

    // ---- start during DONE is dropped ----
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0002; wide = 1'b0; cin_use = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("dstart.done", done, 1'b1);
    start = 1'b1; op = OP_XOR;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dstart.busy", busy, 1'b0);
    chk("dstart.state", dbg_state, 2'd0);
    chk("dstart.result", result, 16'h0003);
    chk("dstart.carry", carry, 1'b0);
    @(posedge clk); #1;
    chk("dstart.still_idle", busy, 1'b0);

    // ---- reset mid-operation ----
    run_op("add_pre", OP_ADD, 16'h00FF, 16'h0002, 1'b0, 1'b0, 1'b0,
           OPF_ADD, 1'b0, 16'h0001, 1'b1, 2, 1'b0);
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 16'h00FF; b = 16'h0001; wide = 1'b1; cin_use = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    if (WIDE_BUILD) begin
      @(posedge clk); #1;
      chk("mid.in_hi", dbg_state, 2'd2);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("mid.busy", busy, 1'b0);
    chk("mid.done", done, 1'b0);
    chk("mid.result", result, 16'h0000);
    chk("mid.carry", carry, 1'b0);
    chk("mid.alu", {alu_a1, alu_a2, alu_opFlag, alu_eFlag, alu_cin}, 26'h0);
    chk("mid.state", dbg_state, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid.no_done", done_cnt - d0, 0);
    chk("mid.carry_after", carry, 1'b0);
    chk("mid.idle_after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
